// File: rtl/vga_tx.sv
// -----------------------------------------------------------------------------
// vga_tx : VGA raster timing generator with a 256x256 grey frame-buffer window
//
// A free-running H/V counter pair produces the raster. A 128x128 frame buffer
// is displayed inside a 256x256 window (2x pixel and line doubling) whose
// top-left corner is WIN_X/WIN_Y in visible coordinates. The pipeline is
// counter -> registered BRAM address -> BRAM data -> output register, so all
// outputs for counter position (h,v) appear three clocks after the counter
// sits at (h,v). The display enable is sampled only at (0,0) so a frame is
// never partially shown.
//
// Ports
//   V_CLK       in   pixel clock (single domain)
//   V_RESET_N   in   asynchronous active-low reset
//   ENABLE      in   frame-buffer display enable (takes effect at next frame)
//   BRAM_ADDR   out  [13:0] frame-buffer read address, registered
//   BRAM_DOUT   in   [7:0] frame-buffer data, valid one clock after BRAM_ADDR
//   V_HS        out  horizontal sync, active low
//   V_VS        out  vertical sync, active low
//   V_DE        out  high during the visible region
//   PIXEL       out  [7:0] grey intensity
//   FRAME_START out  one-clock pulse together with the output of pixel (0,0)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_tx #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int WIN_X  = 64,
  parameter int WIN_Y  = 112
) (
  input  logic        V_CLK,
  input  logic        V_RESET_N,
  input  logic        ENABLE,
  output logic [13:0] BRAM_ADDR,
  input  logic [7:0]  BRAM_DOUT,
  output logic        V_HS,
  output logic        V_VS,
  output logic        V_DE,
  output logic [7:0]  PIXEL,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Per-position attributes travelling down the pipeline alongside the data.
  typedef struct packed {
    logic vis;   // inside the visible region
    logic hs;    // horizontal sync active
    logic vs;    // vertical sync active
    logic show;  // visible, inside the window and frame enabled
    logic fs;    // position (0,0)
  } flags_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          disp_en;

  logic [15:0]   rel_x;
  logic [15:0]   rel_y;
  logic          in_win;
  logic          at_origin;
  logic          frame_en;
  logic [13:0]   addr_next;
  flags_t        flags_c;
  flags_t        s1_flags;
  flags_t        s2_flags;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values present before the clock edge.
  always_ff @(posedge V_CLK or negedge V_RESET_N) begin
    if (!V_RESET_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Counter-stage decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    rel_x     = '0;
    rel_y     = '0;
    in_win    = 1'b0;
    at_origin = 1'b0;
    frame_en  = 1'b0;
    addr_next = '0;
    flags_c   = '0;

    // Wrapping subtraction: positions left of / above the window become huge
    // and fail the < 256 test, so one compare per axis covers both edges.
    rel_x  = 16'(h_cnt) - 16'(WIN_X);
    rel_y  = 16'(v_cnt) - 16'(WIN_Y);
    in_win = (rel_x < 16'd256) && (rel_y < 16'd256);

    // Dropping bit 0 of each relative coordinate gives the 2x doubling.
    addr_next = {rel_y[7:1], rel_x[7:1]};

    at_origin = (h_cnt == '0) && (v_cnt == '0);
    // At (0,0) the freshly sampled ENABLE governs the frame about to start.
    frame_en  = at_origin ? ENABLE : disp_en;

    flags_c.vis  = (h_cnt < HW'(H_VIS)) && (v_cnt < VW'(V_VIS));
    flags_c.hs   = (h_cnt >= HW'(H_VIS + H_FP)) &&
                   (h_cnt <  HW'(H_VIS + H_FP + H_SYNC));
    flags_c.vs   = (v_cnt >= VW'(V_VIS + V_FP)) &&
                   (v_cnt <  VW'(V_VIS + V_FP + V_SYNC));
    flags_c.show = flags_c.vis && in_win && frame_en;
    flags_c.fs   = at_origin;
  end

  // ---------------------------------------------------------------------------
  // Frame enable, address stage and data-alignment stage
  // ---------------------------------------------------------------------------
  // NOTE: the pipeline registers are reset along with the counters so no
  // stale sync or pixel from before reset can reach the outputs afterwards.
  always_ff @(posedge V_CLK or negedge V_RESET_N) begin
    if (!V_RESET_N) begin
      disp_en   <= 1'b0;
      BRAM_ADDR <= '0;
      s1_flags  <= '0;
      s2_flags  <= '0;
    end else begin
      if (at_origin) begin
        disp_en <= ENABLE;
      end
      // Outside the window the address simply holds.
      if (in_win) begin
        BRAM_ADDR <= addr_next;
      end
      s1_flags <= flags_c;
      s2_flags <= s1_flags;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: BRAM_DOUT now belongs to the position held in s2_flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge V_CLK or negedge V_RESET_N) begin
    if (!V_RESET_N) begin
      V_HS        <= 1'b1;
      V_VS        <= 1'b1;
      V_DE        <= 1'b0;
      PIXEL       <= '0;
      FRAME_START <= 1'b0;
    end else begin
      V_HS        <= ~s2_flags.hs;
      V_VS        <= ~s2_flags.vs;
      V_DE        <= s2_flags.vis;
      PIXEL       <= s2_flags.show ? BRAM_DOUT : 8'h00;
      FRAME_START <= s2_flags.fs;
    end
  end

endmodule

// File: tb/tb_vga_tx.sv
// -----------------------------------------------------------------------------
// tb_vga_tx : directed self-checking bench for vga_tx
//
// Two instances share one clock:
//   u_small  16x10-clock raster with the window covering the whole visible area
//            (WIN_X=WIN_Y=0); cheap multi-frame timing, enable and reset runs.
//   u_big    272x264-clock raster with the window at (4,2); window edges,
//            address mapping, latency and the far corner (address 16383).
// Each BRAM model returns addr[7:0] one clock after the address.
// Sample index n = number of rising edges since reset release; the counter is
// at raster position n and the outputs describe position n-3.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_tx;

  // small raster geometry
  localparam int SH_TOT = 16;   // 8 + 2 + 3 + 3
  localparam int SFRAME = 160;  // 16 * 10
  // big raster geometry
  localparam int BH_TOT = 272;  // 264 + 2 + 3 + 3

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] pix;
  } vout_t;

  logic        clk = 1'b0;
  logic        s_rst, s_en, b_rst, b_en;
  logic [13:0] s_addr, b_addr;
  logic [7:0]  s_dout, b_dout;
  logic        s_hs, s_vs, s_de, s_fs, b_hs, b_vs, b_de, b_fs;
  logic [7:0]  s_pix, b_pix;

  int n_cmp = 0;
  int n_bad = 0;
  int n_small = 0;
  int n_big = 0;
  bit frame_en [4];

  always #5 clk = ~clk;

  vga_tx #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .WIN_X(0), .WIN_Y(0)
  ) u_small (
    .V_CLK(clk), .V_RESET_N(s_rst), .ENABLE(s_en),
    .BRAM_ADDR(s_addr), .BRAM_DOUT(s_dout),
    .V_HS(s_hs), .V_VS(s_vs), .V_DE(s_de), .PIXEL(s_pix), .FRAME_START(s_fs)
  );

  vga_tx #(
    .H_VIS(264), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(260), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .WIN_X(4), .WIN_Y(2)
  ) u_big (
    .V_CLK(clk), .V_RESET_N(b_rst), .ENABLE(b_en),
    .BRAM_ADDR(b_addr), .BRAM_DOUT(b_dout),
    .V_HS(b_hs), .V_VS(b_vs), .V_DE(b_de), .PIXEL(b_pix), .FRAME_START(b_fs)
  );

  // Frame-buffer models: data = low byte of the address, one clock latency.
  always @(posedge clk) s_dout <= s_addr[7:0];
  always @(posedge clk) b_dout <= b_addr[7:0];

  // Expected small-raster outputs at sample n, built from the raster formulas.
  function automatic vout_t small_model(input int n);
    vout_t r;
    int p, f, q, h, v, a;
    r = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, pix: 8'h00};
    if (n >= 3) begin
      p = n - 3;
      f = p / SFRAME;
      q = p % SFRAME;
      h = q % SH_TOT;
      v = q / SH_TOT;
      r.de = (h < 8) && (v < 6);
      r.hs = !((h >= 10) && (h < 13));
      r.vs = !((v >= 7) && (v < 9));
      r.fs = (q == 0);
      a = (v / 2) * 128 + (h / 2);
      if (r.de && f < 4 && frame_en[f]) r.pix = 8'(a % 256);
    end
    return r;
  endfunction

  task automatic step_small(output vout_t s);
    @(negedge clk);
    n_small++;
    s = {s_hs, s_vs, s_de, s_fs, s_pix};
  endtask

  task automatic reset_small(input logic en);
    s_rst = 1'b0;
    s_en  = en;
    repeat (2) @(negedge clk);
    s_rst   = 1'b1;
    n_small = 0;
  endtask

  task automatic step_big_to(input int target);
    while (n_big < target) begin
      @(negedge clk);
      n_big++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    s_rst = 1'b0; b_rst = 1'b0; s_en = 1'b0; b_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hs: got %b want 1", s_hs); end
    n_cmp++; if (s_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vs: got %b want 1", s_vs); end
    n_cmp++; if (s_de !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %b want 0", s_de); end
    n_cmp++; if (s_pix !== 8'h00) begin n_bad++; $display("FAIL reset_pixel: got %h want 00", s_pix); end
    n_cmp++; if (s_fs !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %b want 0", s_fs); end
    n_cmp++; if (s_addr !== 14'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", s_addr); end
  endtask

  // Two full frames: sync widths, DE area, FRAME_START period, full stream.
  task automatic test_timing();
    vout_t o, e;
    int errs = 0, first = -1, hs_low = 0, vs_low = 0, de_hi = 0;
    int fs_cnt = 0, fs_first = -1, fs_prev = -1, period = -1;
    for (int i = 0; i < 4; i++) frame_en[i] = 1'b1;
    reset_small(1'b1);
    for (int n = 1; n <= 2 * SFRAME + 2; n++) begin
      step_small(o);
      e = small_model(n_small);
      if (o !== e) begin if (first < 0) first = n; errs++; end
      if (n >= 3) begin
        if (!o.hs) hs_low++;
        if (!o.vs) vs_low++;
        if (o.de)  de_hi++;
        if (o.fs) begin
          fs_cnt++;
          if (fs_first < 0) fs_first = n; else period = n - fs_prev;
          fs_prev = n;
        end
      end
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL timing_stream: %0d cycles differ (first n=%0d), want 0", errs, first); end
    n_cmp++; if (hs_low !== 60) begin n_bad++; $display("FAIL timing_hs_low: got %0d want 60", hs_low); end
    n_cmp++; if (vs_low !== 64) begin n_bad++; $display("FAIL timing_vs_low: got %0d want 64", vs_low); end
    n_cmp++; if (de_hi !== 96) begin n_bad++; $display("FAIL timing_de_high: got %0d want 96", de_hi); end
    n_cmp++; if (fs_cnt !== 2) begin n_bad++; $display("FAIL timing_fs_count: got %0d want 2", fs_cnt); end
    n_cmp++; if (fs_first !== 3) begin n_bad++; $display("FAIL timing_fs_first: got %0d want 3", fs_first); end
    n_cmp++; if (period !== SFRAME) begin n_bad++; $display("FAIL timing_fs_period: got %0d want %0d", period, SFRAME); end
  endtask

  // ENABLE raised mid frame 0 and dropped mid frame 1: only frame 1 shows data.
  task automatic test_enable_gating();
    vout_t o, e;
    int errs = 0, first = -1, hs_low = 0;
    int nz [3] = '{0, 0, 0};
    logic [7:0] spot = 8'h00;
    frame_en[0] = 1'b0; frame_en[1] = 1'b1; frame_en[2] = 1'b0; frame_en[3] = 1'b0;
    reset_small(1'b0);
    for (int n = 1; n <= 3 * SFRAME + 2; n++) begin
      step_small(o);
      if (n == 40)  s_en = 1'b1;
      if (n == 200) s_en = 1'b0;
      e = small_model(n_small);
      if (o !== e) begin if (first < 0) first = n; errs++; end
      if (n >= 3) begin
        if (o.pix != 8'h00) nz[(n - 3) / SFRAME]++;
        if (!o.hs) hs_low++;
      end
      if (n == SFRAME + 2 * SH_TOT + 2 + 3) spot = o.pix;  // frame 1, (2,2)
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL enable_stream: %0d cycles differ (first n=%0d), want 0", errs, first); end
    n_cmp++; if (nz[0] !== 0) begin n_bad++; $display("FAIL enable_frame0_dark: got %0d nonzero pixels want 0", nz[0]); end
    n_cmp++; if (nz[1] !== 40) begin n_bad++; $display("FAIL enable_frame1_data: got %0d nonzero pixels want 40", nz[1]); end
    n_cmp++; if (nz[2] !== 0) begin n_bad++; $display("FAIL enable_frame2_dark: got %0d nonzero pixels want 0", nz[2]); end
    n_cmp++; if (spot !== 8'h81) begin n_bad++; $display("FAIL enable_spot_2_2: got %h want 81", spot); end
    n_cmp++; if (hs_low !== 90) begin n_bad++; $display("FAIL enable_sync_running: got %0d hs-low want 90", hs_low); end
  endtask

  // Asynchronous reset in the middle of the visible area, then restart.
  task automatic test_mid_reset();
    vout_t o;
    for (int i = 0; i < 4; i++) frame_en[i] = 1'b1;
    reset_small(1'b1);
    while (n_small < 53) step_small(o);   // outputs show (2,3), counter at (5,3)
    n_cmp++; if (s_de !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_de: got %b want 1", s_de); end
    n_cmp++; if (s_pix !== 8'h81) begin n_bad++; $display("FAIL midrst_pre_pixel: got %h want 81", s_pix); end
    n_cmp++; if (s_addr !== 14'd130) begin n_bad++; $display("FAIL midrst_pre_addr: got %0d want 130", s_addr); end
    #2 s_rst = 1'b0;
    #1;
    n_cmp++; if (s_de !== 1'b0) begin n_bad++; $display("FAIL midrst_de: got %b want 0", s_de); end
    n_cmp++; if (s_pix !== 8'h00) begin n_bad++; $display("FAIL midrst_pixel: got %h want 00", s_pix); end
    n_cmp++; if (s_addr !== 14'd0) begin n_bad++; $display("FAIL midrst_addr: got %0d want 0", s_addr); end
    n_cmp++; if ({s_hs, s_vs, s_fs} !== 3'b110) begin n_bad++; $display("FAIL midrst_sync: got hs/vs/fs=%b want 110", {s_hs, s_vs, s_fs}); end
    repeat (2) @(negedge clk);
    s_rst   = 1'b1;
    n_small = 0;
    for (int n = 1; n <= 3; n++) begin
      step_small(o);
      n_cmp++;
      if (o.fs !== (n == 3)) begin n_bad++; $display("FAIL midrst_fs_n%0d: got %b want %b", n, o.fs, (n == 3)); end
    end
    n_cmp++; if (o.de !== 1'b1) begin n_bad++; $display("FAIL midrst_restart_de: got %b want 1", o.de); end
  endtask

  // Last raster position rolls over to (0,0) cleanly.
  task automatic test_wrap();
    vout_t o;
    int vs_low = 0, vs_fall = 0;
    logic prev_vs = 1'b1;
    logic [13:0] a160 = '0, a161 = '0, a163 = '0;
    for (int i = 0; i < 4; i++) frame_en[i] = 1'b1;
    reset_small(1'b1);
    for (int n = 1; n <= 163; n++) begin
      step_small(o);
      if (n == 160) a160 = s_addr;
      if (n == 161) a161 = s_addr;
      if (n == 163) a163 = s_addr;
      if (n >= 3 && n <= 162) begin
        if (!o.vs) vs_low++;
        if (prev_vs && !o.vs) vs_fall++;
        prev_vs = o.vs;
      end
      if (n >= 160) begin
        n_cmp++;
        if ({o.de, o.vs, o.fs} !== ((n == 163) ? 3'b111 : 3'b010)) begin
          n_bad++;
          $display("FAIL wrap_flags_n%0d: got de/vs/fs=%b want %b", n, {o.de, o.vs, o.fs}, (n == 163) ? 3'b111 : 3'b010);
        end
      end
    end
    n_cmp++; if (a160 !== 14'd519) begin n_bad++; $display("FAIL wrap_addr_last: got %0d want 519", a160); end
    n_cmp++; if (a161 !== 14'd0) begin n_bad++; $display("FAIL wrap_addr_origin: got %0d want 0", a161); end
    n_cmp++; if (a163 !== 14'd1) begin n_bad++; $display("FAIL wrap_addr_h2: got %0d want 1", a163); end
    n_cmp++; if (vs_low !== 32) begin n_bad++; $display("FAIL wrap_vs_low: got %0d want 32", vs_low); end
    n_cmp++; if (vs_fall !== 1) begin n_bad++; $display("FAIL wrap_vs_pulses: got %0d want 1", vs_fall); end
  endtask

  // Window edges, mapping and pipeline latency on the larger raster.
  task automatic test_window();
    b_en  = 1'b1;
    b_rst = 1'b0;
    repeat (2) @(negedge clk);
    b_rst = 1'b1;
    n_big = 0;
    step_big_to(3);                                  // (0,0) output
    n_cmp++; if ({b_fs, b_de, b_pix} !== {2'b11, 8'h00}) begin n_bad++; $display("FAIL win_origin: got fs/de/pix=%b/%b/%h want 1/1/00", b_fs, b_de, b_pix); end
    step_big_to(2 * BH_TOT + 4 + 1);                 // counter (4,2) + 1
    n_cmp++; if (b_addr !== 14'd0) begin n_bad++; $display("FAIL win_addr_first: got %0d want 0", b_addr); end
    step_big_to(2 * BH_TOT + 3 + 3);                 // output (3,2)
    n_cmp++; if ({b_de, b_pix} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL win_left_outside: got de/pix=%b/%h want 1/00", b_de, b_pix); end
    step_big_to(2 * BH_TOT + 4 + 3);                 // output (4,2)
    n_cmp++; if ({b_de, b_pix} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL win_first_pixel: got de/pix=%b/%h want 1/00", b_de, b_pix); end
    step_big_to(2 * BH_TOT + 6 + 3);                 // output (6,2)
    n_cmp++; if (b_pix !== 8'h01) begin n_bad++; $display("FAIL win_x_double: got %h want 01", b_pix); end
    step_big_to(2 * BH_TOT + 260 + 1);               // counter (260,2) + 1: held
    n_cmp++; if (b_addr !== 14'd127) begin n_bad++; $display("FAIL win_addr_hold: got %0d want 127", b_addr); end
    step_big_to(2 * BH_TOT + 260 + 3);               // output (260,2)
    n_cmp++; if ({b_de, b_pix} !== {1'b1, 8'h00}) begin n_bad++; $display("FAIL win_right_outside: got de/pix=%b/%h want 1/00", b_de, b_pix); end
    step_big_to(4 * BH_TOT + 4);                     // counter (4,4): addr not yet updated
    n_cmp++; if (b_addr !== 14'd127) begin n_bad++; $display("FAIL lat_addr_before: got %0d want 127", b_addr); end
    step_big_to(4 * BH_TOT + 4 + 1);
    n_cmp++; if (b_addr !== 14'd128) begin n_bad++; $display("FAIL lat_addr_t1: got %0d want 128", b_addr); end
    step_big_to(4 * BH_TOT + 4 + 2);
    n_cmp++; if (b_pix !== 8'h00) begin n_bad++; $display("FAIL lat_pixel_t2: got %h want 00", b_pix); end
    step_big_to(4 * BH_TOT + 4 + 3);
    n_cmp++; if ({b_de, b_pix} !== {1'b1, 8'h80}) begin n_bad++; $display("FAIL lat_pixel_t3: got de/pix=%b/%h want 1/80", b_de, b_pix); end
    step_big_to(257 * BH_TOT + 259 + 1);             // counter (259,257) + 1
    n_cmp++; if (b_addr !== 14'd16383) begin n_bad++; $display("FAIL win_addr_corner: got %0d want 16383", b_addr); end
    step_big_to(257 * BH_TOT + 259 + 3);
    n_cmp++; if ({b_de, b_pix} !== {1'b1, 8'hff}) begin n_bad++; $display("FAIL win_corner_pixel: got de/pix=%b/%h want 1/ff", b_de, b_pix); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_enable_gating();
    test_mid_reset();
    test_wrap();
    test_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_tx.md
VGA_TX -- requirements
Module: vga_tx

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters WIN_X / WIN_Y, defaults 64 / 112, top-left of the 256x256 display window in visible coordinates.
REQ-006 SHALL have port V_CLK, input, 1 bit, pixel clock; single clock domain.
REQ-007 SHALL have port V_RESET_N, input, 1 bit, reset, asynchronous, active-low.
REQ-008 SHALL have port ENABLE, input, 1 bit, frame-buffer display enable.
REQ-009 SHALL have port BRAM_ADDR, output, 14 bits, frame-buffer read address, registered.
REQ-010 SHALL have port BRAM_DOUT, input, 8 bits, frame-buffer read data, valid one V_CLK after BRAM_ADDR.
REQ-011 SHALL have port V_HS, output, 1 bit, horizontal sync, active low.
REQ-012 SHALL have port V_VS, output, 1 bit, vertical sync, active low.
REQ-013 SHALL have port V_DE, output, 1 bit, high during visible region.
REQ-014 SHALL have port PIXEL, output, 8 bits, grey intensity.
REQ-015 SHALL have port FRAME_START, output, 1 bit, one-cycle pulse coincident with output of pixel (0,0).

Function
REQ-016 SHALL run H_CNT 0..H_TOTAL-1 (H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800 default), wrapping to 0.
REQ-017 SHALL increment V_CNT 0..V_TOTAL-1 (525 default) when H_CNT wraps, and wrap V_CNT to 0 after V_TOTAL-1.
REQ-018 SHALL decode, at counter stage: visible = H_CNT<H_VIS and V_CNT<V_VIS; hs active for H_VIS+H_FP <= H_CNT < H_VIS+H_FP+H_SYNC; vs active likewise on V_CNT.
REQ-019 SHALL treat in-window as WIN_X <= H_CNT < WIN_X+256 and WIN_Y <= V_CNT < WIN_Y+256.
REQ-020 SHALL use src_x = (H_CNT-WIN_X)>>1 and src_y = (V_CNT-WIN_Y)>>1 (2x pixel and line doubling) with address = src_y*128 + src_x, i.e. {src_y[6:0], src_x[6:0]}.
REQ-021 SHALL register BRAM_ADDR one cycle after the counter stage; outside the window BRAM_ADDR holds its last value.
REQ-022 SHALL present, for counter position (h,v) at cycle t, V_HS/V_VS/V_DE/PIXEL/FRAME_START for that position at cycle t+3 (counter -> address -> BRAM data -> output register); sync and window flags delayed to match.
REQ-023 SHALL set PIXEL = BRAM_DOUT when delayed in-window and display-enabled; 0 when visible but outside window, or when display disabled; 0 whenever V_DE = 0.
REQ-024 SHALL sample ENABLE into display-enabled only when H_CNT=0 and V_CNT=0; mid-frame ENABLE changes take effect at the next frame (no tearing).
REQ-025 SHALL keep sync generation running regardless of ENABLE.
REQ-026 SHALL require WIN_X+256 <= H_VIS and WIN_Y+256 <= V_VIS; other values are unsupported.
REQ-027 SHALL make all outputs registered, with no combinational path from BRAM_DOUT or ENABLE to any output.

Reset
REQ-028 SHALL, while V_RESET_N=0, force H_CNT=0, V_CNT=0, BRAM_ADDR=0, V_HS=1, V_VS=1, V_DE=0, PIXEL=0, FRAME_START=0, display-enabled=0, and clear all pipeline stages.
REQ-029 SHALL, after V_RESET_N deasserts, start counting at (0,0) on the first V_CLK edge; first FRAME_START occurs 3 cycles later only if ENABLE is sampled, else still pulses (FRAME_START is independent of ENABLE).
REQ-030 SHALL, on reset asserted mid-frame, apply REQ-028 immediately (asynchronously) and restart the frame from (0,0) on release.

Verification
REQ-031 SHALL check timing: release reset, run 2 frames -> V_HS low 96 clocks every 800; V_VS low 2 lines every 525; V_DE high 640x480 per frame; FRAME_START period 420000 clocks.
REQ-032 SHALL check window mapping: BRAM model returns addr[7:0], ENABLE=1 -> at visible (64,112) PIXEL=0x00, (66,112) PIXEL=0x01, (64,114) uses addr 128, (319,367) uses addr 16383, (63,112) and (320,112) PIXEL=0.
REQ-033 SHALL check latency: counter at (64,112) at cycle t -> BRAM_ADDR=0 at t+1; PIXEL=BRAM data at t+3, aligned with V_DE.
REQ-034 SHALL check ENABLE gating: raise ENABLE mid-frame -> PIXEL stays 0 for rest of that frame, shows data from next FRAME_START; sync unaffected.
REQ-035 SHALL check mid-frame reset: assert V_RESET_N=0 at (400,300) -> outputs at reset values same cycle; after release, first FRAME_START exactly 3 cycles later.
REQ-036 SHALL check wrap: at H_CNT=799,V_CNT=524 -> next counter (0,0), no spurious V_DE or extra V_VS pulse.
